// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: stall/nullify per pipeline register, mul/div occupancy.
// Latency: stall/nullify/pc_redirect are combinational (zero-cycle); state and md_cnt update on clk.
// Backpressure: stall[0] holds PC and F/D; structural mul/div conflicts also hold D/E. HAZARD_PERF_COUNTER_EN adds a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_in_ex,
  input  logic [4:0] ex_dest,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       branch_taken_ex,
  input  logic       exception_mem,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       md_read_id,
  output logic [3:0] stall,
  output logic [3:0] nullify,
  output logic       pc_redirect,
  output logic       md_busy
`ifdef HAZARD_PERF_COUNTER_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_WAIT   = 2'd1,
    EXC_FLUSH = 2'd2
  } state_t;

  // Counter reload values: the unit is busy for exactly N cycles, counting N-1 down to 0.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state;
  logic [5:0] md_cnt;
  logic       load_use;
  logic       md_struct;
  logic       md_hilo;

  // Load-use: EX load writes a register the ID instruction actually reads ($0 never hazards).
  always_comb begin
    load_use = 1'b0;
    if (load_in_ex && (ex_dest != 5'd0)) begin
      load_use = (id_uses_rs && (id_rs == ex_dest)) ||
                 (id_uses_rt && (id_rt == ex_dest));
    end
  end

  assign md_struct = (state == MD_WAIT) && md_start;
  assign md_hilo   = (state == MD_WAIT) && md_read_id;

  // Priority-encoded hazard resolution; only the highest active cause drives the outputs.
  always_comb begin
    stall       = 4'b0000;
    nullify     = 4'b0000;
    pc_redirect = 1'b0;
    md_busy     = 1'b0;
    if (!reset) begin
      // Keep every pipeline register empty while reset is held.
      nullify = 4'b1111;
    end else begin
      md_busy = (state == MD_WAIT);
      if (exception_mem) begin
        nullify     = 4'b1111;
        pc_redirect = 1'b1;
      end else if (state == EXC_FLUSH) begin
        // Synchronous fetch returned the pre-redirect instruction; squash it only.
        nullify = 4'b0001;
      end else if (branch_taken_ex) begin
        nullify = 4'b0011;
      end else if (md_struct) begin
        // Hold the new mul/div in EX and bubble E/M until the unit frees.
        stall   = 4'b0011;
        nullify = 4'b0100;
      end else if (md_hilo) begin
        stall   = 4'b0001;
        nullify = 4'b0010;
      end else if (load_use) begin
        stall   = 4'b0001;
        nullify = 4'b0010;
      end
    end
  end

  // Control FSM and mul/div down-counter; reset and exceptions abandon any operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= RUN;
      md_cnt <= 6'd0;
    end else if (exception_mem) begin
      state  <= EXC_FLUSH;
      md_cnt <= 6'd0;
    end else begin
      case (state)
        RUN: begin
          if (md_start) begin
            state  <= MD_WAIT;
            md_cnt <= md_is_div ? DIV_LOAD : MUL_LOAD;
          end
        end
        MD_WAIT: begin
          if (md_cnt == 6'd0) begin
            // Back-to-back issue: accept the waiting op as the old one retires.
            if (md_start && !branch_taken_ex) begin
              state  <= MD_WAIT;
              md_cnt <= md_is_div ? DIV_LOAD : MUL_LOAD;
            end else begin
              state  <= RUN;
            end
          end else begin
            md_cnt <= md_cnt - 6'd1;
          end
        end
        EXC_FLUSH: begin
          state <= RUN;
        end
        default: begin
          state  <= RUN;
          md_cnt <= 6'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTER_EN
  // Saturating count of cycles in which fetch/PC were held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cycles <= 32'd0;
    end else if (stall[0] && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs, a monitor compares.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected record layout: {stall[3:0], nullify[3:0], pc_redirect, md_busy}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_in_ex;
  logic [4:0] ex_dest;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       branch_taken_ex;
  logic       exception_mem;
  logic       md_start;
  logic       md_is_div;
  logic       md_read_id;
  logic [3:0] stall;
  logic [3:0] nullify;
  logic       pc_redirect;
  logic       md_busy;
`ifdef HAZARD_PERF_COUNTER_EN
  logic [31:0] perf_stall_cycles;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] exp_q[$];
  string      nm_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_in_ex      (load_in_ex),
    .ex_dest         (ex_dest),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .branch_taken_ex (branch_taken_ex),
    .exception_mem   (exception_mem),
    .md_start        (md_start),
    .md_is_div       (md_is_div),
    .md_read_id      (md_read_id),
    .stall           (stall),
    .nullify         (nullify),
    .pc_redirect     (pc_redirect),
    .md_busy         (md_busy)
`ifdef HAZARD_PERF_COUNTER_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  function automatic logic [9:0] ex(input logic [3:0] s, input logic [3:0] n,
                                    input logic p, input logic b);
    return {s, n, p, b};
  endfunction

  task automatic idle();
    load_in_ex = 0; ex_dest = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; branch_taken_ex = 0;
    exception_mem = 0; md_start = 0; md_is_div = 0; md_read_id = 0;
  endtask

  // Inputs are already set; record what this cycle must produce, then advance one cycle.
  task automatic step(input string nm, input logic [9:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a pending expectation is compared against the DUT outputs.
  initial begin
    logic [9:0] e;
    logic [9:0] got;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = nm_q.pop_front();
        got = {stall, nullify, pc_redirect, md_busy};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s: got stall=%b nullify=%b pcr=%b busy=%b, want stall=%b nullify=%b pcr=%b busy=%b",
                   nm, got[9:6], got[5:2], got[1], got[0], e[9:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int waited;
    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: everything nullified, nothing stalled.
    step("reset0", ex(4'h0, 4'hF, 0, 0));
    load_in_ex = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1; exception_mem = 1;
    step("reset_override", ex(4'h0, 4'hF, 0, 0));
    idle();
    reset = 1'b1;
    step("idle_after_reset", ex(4'h0, 4'h0, 0, 0));

    // Load-use through rs, then gone next cycle.
    load_in_ex = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
    step("load_use_rs", ex(4'h1, 4'h2, 0, 0));
    idle();
    step("load_use_clear", ex(4'h0, 4'h0, 0, 0));
    load_in_ex = 1; ex_dest = 0; id_rs = 0; id_uses_rs = 1;
    step("load_use_r0", ex(4'h0, 4'h0, 0, 0));
    idle();
    load_in_ex = 1; ex_dest = 7; id_rt = 7; id_uses_rt = 1;
    step("load_use_rt", ex(4'h1, 4'h2, 0, 0));
    id_uses_rt = 0;
    step("load_rt_unused", ex(4'h0, 4'h0, 0, 0));
    id_uses_rt = 1; branch_taken_ex = 1;
    step("branch_over_load_use", ex(4'h0, 4'h3, 0, 0));
    idle();

    // Divide, then HI/LO read held for the whole 32-cycle occupancy and one more.
    md_start = 1; md_is_div = 1;
    step("div_issue", ex(4'h0, 4'h0, 0, 0));
    idle();
    md_read_id = 1;
    for (int i = 0; i < 32; i++) step("div_hilo_wait", ex(4'h1, 4'h2, 0, 1));
    step("div_done_hilo", ex(4'h0, 4'h0, 0, 0));
    idle();

    // Exception together with branch during a multiply.
    md_start = 1;
    step("mul_issue", ex(4'h0, 4'h0, 0, 0));
    idle();
    step("mul_busy", ex(4'h0, 4'h0, 0, 1));
    exception_mem = 1; branch_taken_ex = 1;
    step("exc_in_md_wait", ex(4'h0, 4'hF, 1, 1));
    idle();
    load_in_ex = 1; ex_dest = 3; id_rs = 3; id_uses_rs = 1;
    step("exc_flush", ex(4'h0, 4'h1, 0, 0));
    idle();
    step("exc_back_to_run", ex(4'h0, 4'h0, 0, 0));

    // Exception re-entering EXC_FLUSH.
    exception_mem = 1;
    step("exc_run", ex(4'h0, 4'hF, 1, 0));
    step("exc_again", ex(4'h0, 4'hF, 1, 0));
    idle();
    step("exc_flush2", ex(4'h0, 4'h1, 0, 0));
    step("exc_run2", ex(4'h0, 4'h0, 0, 0));

    // Reset on the 3rd cycle of a multiply abandons it.
    md_start = 1;
    step("mul2_issue", ex(4'h0, 4'h0, 0, 0));
    idle();
    step("mul2_busy1", ex(4'h0, 4'h0, 0, 1));
    reset = 1'b0;
    step("mul2_reset", ex(4'h0, 4'hF, 0, 0));
    md_read_id = 1;
    step("mul2_reset_hold", ex(4'h0, 4'hF, 0, 0));
    reset = 1'b1;
    step("mul2_after_reset", ex(4'h0, 4'h0, 0, 0));
    idle();

    // Structural hazard: second multiply waits, reloads at md_cnt==0.
    md_start = 1;
    step("mul3_issue", ex(4'h0, 4'h0, 0, 0));
    md_read_id = 1; load_in_ex = 1; ex_dest = 9; id_rs = 9; id_uses_rs = 1;
    step("md_struct_prio", ex(4'h3, 4'h4, 0, 1));
    md_read_id = 0; load_in_ex = 0;
    for (int i = 0; i < 3; i++) step("md_struct", ex(4'h3, 4'h4, 0, 1));
    idle();
    for (int i = 0; i < 4; i++) step("mul4_busy", ex(4'h0, 4'h0, 0, 1));
    step("mul4_done", ex(4'h0, 4'h0, 0, 0));

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

`ifdef HAZARD_PERF_COUNTER_EN
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    load_in_ex = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
    repeat (10) @(posedge clk);
    #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (perf_stall_cycles !== 32'd10) begin
      miscompares++;
      $display("FAIL perf_count: got %0d, want 10", perf_stall_cycles);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
